// File: rtl/rv32i_types.sv
// Shared RV32M types for the iterative multiply/divide unit: funct3 opcodes,
// FSM states and small opcode-classification helpers.
package rv32i_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // funct3 bit 1 selects the remainder within the divide family
  function automatic logic is_rem(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic signed_a(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic signed_b(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// Combinational UNROLL-deep restoring-division step on unsigned magnitudes.
// Quotient bits shift into the LSB of the dividend register as its MSBs are consumed.
module ex_muldiv_div_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] dividend_in,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] dividend_out
);

  logic [XLEN:0] trial;

  always_comb begin
    rem_out      = rem_in;
    dividend_out = dividend_in;
    trial        = '0;
    for (int i = 0; i < UNROLL; i++) begin
      trial        = {rem_out, dividend_out[XLEN-1]};
      dividend_out = {dividend_out[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, divisor}) begin
        trial           = trial - {1'b0, divisor};
        dividend_out[0] = 1'b1;
      end
      rem_out = trial[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit (IDLE/CALC/DONE), UNROLL bits per cycle.
// Optional last-result pair cache enabled by defining MULDIV_PAIR_CACHE_EN.
module ex_muldiv
  import rv32i_types::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output muldiv_state_t   dbg_state
);

  // Handshake: an op is taken on a rising edge where start=1, ready=1 and flush=0;
  // done pulses for one cycle with result/rd_out already valid, and flush always wins.
  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(N - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t state, state_next;

  muldiv_op_t        op_q;
  logic [4:0]        rd_q;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   divisor_q;
  logic [2*XLEN-1:0] prod_q, prod_step, prod_fix;
  logic [XLEN-1:0]   rem_q, rem_step, rem_fix;
  logic [XLEN-1:0]   quo_q, quo_step, quo_fix;
  logic              neg_res, neg_rem;

  logic              accept, last;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              special;
  logic [XLEN-1:0]   spec_hi, spec_lo, spec_res;
  logic [XLEN-1:0]   calc_res;
  logic              hit;
  logic [XLEN-1:0]   hit_res;

  assign accept    = (state == ST_IDLE) && start && !flush;
  assign last      = (cnt == LAST);
  assign ready     = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  // Operand decode at accept time
  always_comb begin
    sa      = a[XLEN-1] & signed_a(op);
    sb      = b[XLEN-1] & signed_b(op);
    a_mag   = sa ? (~a + 1'b1) : a;
    b_mag   = sb ? (~b + 1'b1) : b;
    special = 1'b0;
    spec_hi = '0;
    spec_lo = '0;
    if (is_div(op) && (b == '0)) begin
      special = 1'b1;
      spec_lo = '1;
      spec_hi = a;
    end else if ((op == OP_DIV || op == OP_REM) && (a == MIN_NEG) && (b == '1)) begin
      special = 1'b1;
      spec_lo = a;
      spec_hi = '0;
    end
    spec_res = is_rem(op) ? spec_hi : spec_lo;
  end

  // Shift-add multiply: low half holds the remaining multiplier bits
  always_comb begin : mul_step
    logic [XLEN:0] sum;
    prod_step = prod_q;
    sum       = '0;
    for (int i = 0; i < UNROLL; i++) begin
      sum       = {1'b0, prod_step[2*XLEN-1:XLEN]} + (prod_step[0] ? {1'b0, divisor_q} : '0);
      prod_step = {sum, prod_step[XLEN-1:1]};
    end
  end

  ex_muldiv_div_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_div_step (
    .rem_in       (rem_q),
    .divisor      (divisor_q),
    .dividend_in  (quo_q),
    .rem_out      (rem_step),
    .dividend_out (quo_step)
  );

  always_comb begin
    prod_fix = neg_res ? (~prod_step + 1'b1) : prod_step;
    quo_fix  = neg_res ? (~quo_step + 1'b1) : quo_step;
    rem_fix  = neg_rem ? (~rem_step + 1'b1) : rem_step;
    if (is_div(op_q))
      calc_res = is_rem(op_q) ? rem_fix : quo_fix;
    else
      calc_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_PAIR_CACHE_EN
  logic            c_valid, c_div;
  logic [1:0]      c_cls;
  logic [XLEN-1:0] c_a, c_b, c_hi, c_lo;
  logic [XLEN-1:0] a_q, b_q;

  assign hit = c_valid && (c_div == is_div(op)) && (c_a == a) && (c_b == b)
            && (c_cls == {signed_a(op), signed_b(op)});

  // Divide family stores remainder/quotient in hi/lo; MUL shares lo with MULHU's pair
  always_comb begin
    if (is_div(op))
      hit_res = is_rem(op) ? c_hi : c_lo;
    else
      hit_res = (op == OP_MUL) ? c_lo : c_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_div   <= 1'b0;
      c_cls   <= '0;
      c_a     <= '0;
      c_b     <= '0;
      c_hi    <= '0;
      c_lo    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      if (special) begin
        c_valid <= 1'b1;
        c_div   <= 1'b1;
        c_cls   <= {signed_a(op), signed_b(op)};
        c_a     <= a;
        c_b     <= b;
        c_hi    <= spec_hi;
        c_lo    <= spec_lo;
      end
    end else if (state == ST_CALC && last) begin
      c_valid <= 1'b1;
      c_div   <= is_div(op_q);
      c_cls   <= {signed_a(op_q), signed_b(op_q)};
      c_a     <= a_q;
      c_b     <= b_q;
      c_hi    <= is_div(op_q) ? rem_fix : prod_fix[2*XLEN-1:XLEN];
      c_lo    <= is_div(op_q) ? quo_fix : prod_fix[XLEN-1:0];
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (special || hit) ? ST_DONE : ST_CALC;
      ST_CALC: if (last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      rd_q      <= '0;
      cnt       <= '0;
      divisor_q <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else if (accept) begin
      op_q      <= op;
      rd_q      <= rd_in;
      cnt       <= '0;
      divisor_q <= b_mag;
      prod_q    <= {{XLEN{1'b0}}, a_mag};
      rem_q     <= '0;
      quo_q     <= a_mag;
      neg_res   <= sa ^ sb;
      neg_rem   <= sa;
      if (special) begin
        result <= spec_res;
        rd_out <= rd_in;
      end else if (hit) begin
        result <= hit_res;
        rd_out <= rd_in;
      end
    end else if (state == ST_CALC && !flush) begin
      cnt    <= cnt + 1'b1;
      prod_q <= prod_step;
      rem_q  <= rem_step;
      quo_q  <= quo_step;
      if (last) begin
        result <= calc_res;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32, UNROLL=1): directed RV32M vectors,
// flush/reset aborts, busy-start rejection, back-to-back timing and randomized ops.
module tb_ex_muldiv;
  import rv32i_types::*;

  localparam int XLEN = 32;
  localparam int N    = 32;
  localparam int TCLK = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  muldiv_op_t    op;
  logic [31:0]   a, b;
  logic [4:0]    rd_in;
  logic          flush;
  logic          ready, done;
  logic [31:0]   result;
  logic [4:0]    rd_out;
  muldiv_state_t dbg_state;

  ex_muldiv #(.XLEN(XLEN), .UNROLL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .flush     (flush),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #(TCLK/2) clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;
  logic [4:0]  last_rd     = '0;
  time         accept_t    = 0;

  // Model of the last-completed-operation cache
  bit          cv = 0;
  logic [31:0] ca = '0, cb = '0;
  bit          cdiv = 0;
  logic [1:0]  ccls = '0;

  function automatic logic [1:0] op_cls(input muldiv_op_t o);
    case (o)
      OP_MULH, OP_DIV, OP_REM: return 2'b11;
      OP_MULHSU:               return 2'b10;
      default:                 return 2'b00;
    endcase
  endfunction

  function automatic bit is_special(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    if (o == OP_DIV || o == OP_DIVU || o == OP_REM || o == OP_REMU) begin
      if (y == 32'd0) return 1;
      if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] ref_result(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, p;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      OP_MUL:    begin up = ux * uy; return up[31:0]; end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * longint'(uy); return p[63:32]; end
      OP_MULHU:  begin up = ux * uy; return up[63:32]; end
      OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      OP_DIVU: begin
        if (y == 0) return 32'hFFFF_FFFF;
        up = ux / uy; return up[31:0];
      end
      OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        up = ux % uy; return up[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    if (is_special(o, x, y)) return 1;
`ifdef MULDIV_PAIR_CACHE_EN
    if (cv && cdiv == o[2] && ca == x && cb == y && ccls == op_cls(o)) return 1;
`endif
    return N + 1;
  endfunction

  // Entered at a falling edge with the unit idle; leaves at the falling edge after done.
  task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] rd, input logic [31:0] expv, input bit poke,
                        input string name);
    int          lat, elat;
    bit          got, busy_bad;
    logic [31:0] want;
    elat = exp_latency(o, x, y);
    exp_q.push_back(expv);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, ready);
    end
    start = 1'b1; op = o; a = x; b = y; rd_in = rd;
    @(posedge clk);
    accept_t = $time;
    lat = 0; got = 0; busy_bad = 0;
    while (!got && lat < 4 * N) begin
      @(negedge clk);
      lat++;
      start = (poke && lat < N / 2) ? 1'b1 : 1'b0;
      op    = muldiv_op_t'($urandom_range(0, 7));
      a     = $urandom;
      b     = $urandom;
      rd_in = 5'($urandom);
      if (ready !== 1'b0) busy_bad = 1;
      if (done === 1'b1) got = 1;
    end
    start = 1'b0;
    want = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s done_timeout got=none want=done within %0d cycles", name, 4 * N);
    end
    n_checks++;
    if (lat != elat) begin
      n_fail++;
      $display("FAIL %s latency got=%0d want=%0d", name, lat, elat);
    end
    n_checks++;
    if (result !== want) begin
      n_fail++;
      $display("FAIL %s result got=%h want=%h", name, result, want);
    end
    n_checks++;
    if (rd_out !== rd) begin
      n_fail++;
      $display("FAIL %s rd_out got=%0d want=%0d", name, rd_out, rd);
    end
    n_checks++;
    if (busy_bad) begin
      n_fail++;
      $display("FAIL %s ready_while_busy got=1 want=0", name);
    end
    last_result = want;
    last_rd     = rd;
    cv = 1; ca = x; cb = y; cdiv = o[2]; ccls = op_cls(o);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_done got done=%b ready=%b want done=0 ready=1", name, done, ready);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_ctrl got ready=%b done=%b state=%0d want 1 0 0", ready, done, dbg_state);
    end
    n_checks++;
    if (result !== 32'd0 || rd_out !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data got result=%h rd_out=%0d want 0 0", result, rd_out);
    end
  endtask

  task automatic test_directed();
    muldiv_op_t  t_op[12];
    logic [31:0] t_a[12], t_b[12], t_exp[12];
    t_op = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
             OP_DIVU, OP_REMU, OP_DIV, OP_REMU, OP_DIV, OP_REM};
    t_a  = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd7, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    t_b  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
             32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    t_exp = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
              32'd3, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 12; i++)
      run_op(t_op[i], t_a[i], t_b[i], 5'(i + 1), t_exp[i], 1'b0, $sformatf("dir%0d_%s", i, t_op[i].name()));
  endtask

  task automatic test_cache();
    run_op(OP_DIV, 32'd100, 32'd7, 5'd20, 32'd14, 1'b0, "cache_div_100_7");
    run_op(OP_REM, 32'd100, 32'd7, 5'd21, 32'd2,  1'b0, "cache_rem_100_7");
    run_op(OP_REM, 32'd100, 32'd6, 5'd22, 32'd4,  1'b0, "cache_rem_100_6");
  endtask

  task automatic test_busy_start();
    run_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11,
           ref_result(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1, "busy_start_ignored");
  endtask

  task automatic test_flush();
    bit saw_done;
    saw_done = 0;
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3; rd_in = 5'd9;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) saw_done = 1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cv = 0;
    if (done === 1'b1) saw_done = 1;
    n_checks++;
    if (ready !== 1'b1 || saw_done) begin
      n_fail++;
      $display("FAIL flush_abort got ready=%b saw_done=%b want ready=1 saw_done=0", ready, saw_done);
    end
    n_checks++;
    if (result !== last_result || rd_out !== last_rd) begin
      n_fail++;
      $display("FAIL flush_hold got result=%h rd=%0d want result=%h rd=%0d", result, rd_out, last_result, last_rd);
    end
    // flush and start together: the start must be dropped
    start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9; rd_in = 5'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wins got ready=%b done=%b want ready=1 done=0", ready, done);
    end
    run_op(OP_MUL, 32'd3, 32'd4, 5'd12, 32'd12, 1'b0, "mul_after_flush");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = OP_DIVU; a = 32'd77777; b = 32'd13; rd_in = 5'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_calc got ready=%b done=%b result=%h rd=%0d want 1 0 0 0",
               ready, done, result, rd_out);
    end
    cv = 0; last_result = '0; last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    time t0;
    run_op(OP_MULH, 32'hDEAD_BEEF, 32'h0000_1001, 5'd30,
           ref_result(OP_MULH, 32'hDEAD_BEEF, 32'h0000_1001), 1'b0, "b2b_first");
    t0 = accept_t;
    run_op(OP_DIVU, 32'hCAFE_F00D, 32'd1234, 5'd31,
           ref_result(OP_DIVU, 32'hCAFE_F00D, 32'd1234), 1'b0, "b2b_second");
    n_checks++;
    if (accept_t - t0 != time'(TCLK * (N + 2))) begin
      n_fail++;
      $display("FAIL b2b_period got=%0t want=%0d", accept_t - t0, TCLK * (N + 2));
    end
  endtask

  task automatic test_random();
    muldiv_op_t  o;
    logic [31:0] x, y, px, py;
    px = 32'd1; py = 32'd1;
    for (int i = 0; i < 40; i++) begin
      o = muldiv_op_t'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       begin x = $urandom; y = 32'd0; end
        1:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2, 3:    begin x = px; y = py; end
        4:       begin x = 32'($urandom_range(0, 300)); y = 32'($urandom_range(1, 20)); end
        default: begin x = $urandom; y = $urandom; end
      endcase
      run_op(o, x, y, 5'($urandom), ref_result(o, x, y), 1'b0,
             $sformatf("rand%0d_%s_%h_%h", i, o.name(), x, y));
      px = x; py = y;
    end
  endtask

  initial begin
    #(TCLK * 60000);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = OP_MUL;
    a = '0; b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_cache();
    test_busy_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
